// File: rtl/gtxe2_chnl_rx_sync_ctl_pkg.sv
// Shared definitions for the GTXE2 receive-channel link synchronisation controller.
package gtxe2_chnl_rx_pkg;

  // Controller states; the numeric values are visible on the state output port.
  typedef enum logic [1:0] {
    SYNC_IDLE    = 2'd0,
    SYNC_ALIGN   = 2'd1,
    SYNC_ACQUIRE = 2'd2,
    SYNC_SYNC    = 2'd3
  } sync_state_e;

  // Ceiling log2 used to size the counters; never returns less than one bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_sync_ctl_errmon.sv
// Leaky-bucket error monitor used while the link is in SYNC. Every errored
// word adds one credit and restarts the good-word run; each full run of clean
// words removes one credit. threshold_hit flags the errored word that would
// bring the credit count up to the drop threshold.
module gtxe2_chnl_rx_errmon
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int ERR_THRESH = 4,
  parameter int GOOD_RUN   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic err_w,
  input  logic clean_w,
  input  logic clear,
  output logic threshold_hit
);

  localparam int CredW = clog2(ERR_THRESH + 1);
  localparam int RunW  = clog2(GOOD_RUN + 1);

  localparam logic [CredW-1:0] CredLast = CredW'(ERR_THRESH - 1);
  localparam logic [CredW-1:0] CredMax  = CredW'(ERR_THRESH);
  localparam logic [RunW-1:0]  RunLast  = RunW'(GOOD_RUN - 1);

  logic [CredW-1:0] errCred_q;
  logic [CredW-1:0] errCred_d;
  logic [RunW-1:0]  runCnt_q;
  logic [RunW-1:0]  runCnt_d;

  // The drop decision is taken on the errored word itself so the owning FSM
  // can leave SYNC on the same edge the last credit would be added.
  always_comb begin
    threshold_hit = err_w && (errCred_q == CredLast);
  end

  // Credit and run bookkeeping; clear wins so counters start fresh on SYNC entry.
  always_comb begin
    errCred_d = errCred_q;
    runCnt_d  = runCnt_q;
    if (clear) begin
      errCred_d = '0;
      runCnt_d  = '0;
    end else if (err_w) begin
      runCnt_d = '0;
      if (errCred_q != CredMax) begin
        errCred_d = errCred_q + 1'b1;
      end
    end else if (clean_w) begin
      if (runCnt_q == RunLast) begin
        runCnt_d = '0;
        if (errCred_q != '0) begin
          errCred_d = errCred_q - 1'b1;
        end
      end else begin
        runCnt_d = runCnt_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errCred_q <= '0;
      runCnt_q  <= '0;
    end else begin
      errCred_q <= errCred_d;
      runCnt_q  <= runCnt_d;
    end
  end

endmodule

// File: rtl/gtxe2_chnl_rx_sync_ctl.sv
// Link synchronisation controller for the GTXE2 receive channel. Sequences the
// comma aligner enables, watches the 8b/10b decoder status to declare or drop
// sync, and optionally flips lane polarity when alignment is never found.
module gtxe2_chnl_rx_sync_ctl
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int BYTES         = 2,
  parameter int ALIGN_TIMEOUT = 1024,
  parameter int ACQ_COMMAS    = 4,
  parameter int ERR_THRESH    = 4,
  parameter int GOOD_RUN      = 16,
  parameter int AUTO_POLARITY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rx_elecidle,
  input  logic             rx_byteisaligned,
  input  logic             rx_byterealign,
  input  logic [BYTES-1:0] rx_chariscomma,
  input  logic [BYTES-1:0] rx_disperr,
  input  logic [BYTES-1:0] rx_notintable,
  output logic             rx_commadeten,
  output logic             rx_pcommaalignen,
  output logic             rx_mcommaalignen,
  output logic             rx_polarity,
  output logic             link_up,
  output logic [1:0]       state,
  output logic [7:0]       flip_cnt
);

  localparam int TimerW = clog2(ALIGN_TIMEOUT);
  localparam int AcqW   = clog2(ACQ_COMMAS + 1);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(ALIGN_TIMEOUT - 1);
  localparam logic [AcqW-1:0]   AcqLast   = AcqW'(ACQ_COMMAS - 1);

  sync_state_e       state_q;
  sync_state_e       state_d;
  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_d;
  logic [AcqW-1:0]   acqCnt_q;
  logic [AcqW-1:0]   acqCnt_d;
  logic              polarity_q;
  logic              polarity_d;
  logic [7:0]        flipCnt_q;
  logic [7:0]        flipCnt_d;

  logic errW;
  logic commaW;
  logic cleanW;
  logic monClear;
  logic thresholdHit;

  // Collapse the per-byte decoder flags into one status per received word.
  always_comb begin
    errW   = |(rx_disperr | rx_notintable);
    commaW = |rx_chariscomma;
    cleanW = !errW;
  end

  // Next-state logic. Timer and acquisition count default to zero so they are
  // cleared whenever their state is left; polarity and flip count only move on
  // an alignment timeout and survive everything except reset.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    acqCnt_d   = '0;
    polarity_d = polarity_q;
    flipCnt_d  = flipCnt_q;

    if (!enable || rx_elecidle) begin
      state_d = SYNC_IDLE;
    end else begin
      case (state_q)
        SYNC_IDLE: begin
          state_d = SYNC_ALIGN;
        end

        SYNC_ALIGN: begin
          if (rx_byteisaligned) begin
            state_d = SYNC_ACQUIRE;
          end else if (timer_q == TimerLast) begin
            if (AUTO_POLARITY != 0) begin
              polarity_d = !polarity_q;
              if (flipCnt_q != 8'hFF) begin
                flipCnt_d = flipCnt_q + 8'd1;
              end
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        SYNC_ACQUIRE: begin
          if (errW || rx_byterealign || !rx_byteisaligned) begin
            state_d = SYNC_ALIGN;
          end else if (commaW) begin
            if (acqCnt_q == AcqLast) begin
              state_d = SYNC_SYNC;
            end else begin
              acqCnt_d = acqCnt_q + 1'b1;
            end
          end else begin
            acqCnt_d = acqCnt_q;
          end
        end

        SYNC_SYNC: begin
          if (rx_byterealign || thresholdHit) begin
            state_d = SYNC_ALIGN;
          end
        end

        default: begin
          state_d = SYNC_IDLE;
        end
      endcase
    end
  end

  // The error monitor only counts words seen while staying in SYNC; entering
  // or leaving SYNC restarts it from zero.
  always_comb begin
    monClear = (state_q != SYNC_SYNC) || (state_d != SYNC_SYNC);
  end

  gtxe2_chnl_rx_errmon #(
    .ERR_THRESH (ERR_THRESH),
    .GOOD_RUN   (GOOD_RUN)
  ) u_errmon (
    .clk           (clk),
    .rst_n         (rst_n),
    .err_w         (errW),
    .clean_w       (cleanW),
    .clear         (monClear),
    .threshold_hit (thresholdHit)
  );

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SYNC_IDLE;
      timer_q    <= '0;
      acqCnt_q   <= '0;
      polarity_q <= 1'b0;
      flipCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      acqCnt_q   <= acqCnt_d;
      polarity_q <= polarity_d;
      flipCnt_q  <= flipCnt_d;
    end
  end

  // Receiver control outputs decoded from the registered state only.
  always_comb begin
    rx_commadeten    = (state_q != SYNC_IDLE);
    rx_pcommaalignen = (state_q == SYNC_ALIGN);
    rx_mcommaalignen = (state_q == SYNC_ALIGN);
    link_up          = (state_q == SYNC_SYNC);
    rx_polarity      = polarity_q;
    state            = state_q;
    flip_cnt         = flipCnt_q;
  end

endmodule

// File: tb/tb_gtxe2_chnl_rx_sync_ctl.sv
// Self-checking bench for gtxe2_chnl_rx_sync_ctl: directed scenarios with
// fixed expectations, then randomized traffic against a behavioural model.
module tb_gtxe2_chnl_rx_sync_ctl;

  localparam int BYTES   = 2;
  localparam int TIMEOUT = 16;
  localparam int ACQ     = 4;
  localparam int THRESH  = 4;
  localparam int GOOD    = 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             rx_elecidle;
  logic             rx_byteisaligned;
  logic             rx_byterealign;
  logic [BYTES-1:0] rx_chariscomma;
  logic [BYTES-1:0] rx_disperr;
  logic [BYTES-1:0] rx_notintable;
  logic             rx_commadeten;
  logic             rx_pcommaalignen;
  logic             rx_mcommaalignen;
  logic             rx_polarity;
  logic             link_up;
  logic [1:0]       state;
  logic [7:0]       flip_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state (plain integers, spec-level rules).
  int mState = 0;
  int mTimer = 0;
  int mAcq   = 0;
  int mCred  = 0;
  int mRun   = 0;
  int mFlip  = 0;
  bit mPol   = 1'b0;

  gtxe2_chnl_rx_sync_ctl #(
    .BYTES         (BYTES),
    .ALIGN_TIMEOUT (TIMEOUT),
    .ACQ_COMMAS    (ACQ),
    .ERR_THRESH    (THRESH),
    .GOOD_RUN      (GOOD),
    .AUTO_POLARITY (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .rx_elecidle      (rx_elecidle),
    .rx_byteisaligned (rx_byteisaligned),
    .rx_byterealign   (rx_byterealign),
    .rx_chariscomma   (rx_chariscomma),
    .rx_disperr       (rx_disperr),
    .rx_notintable    (rx_notintable),
    .rx_commadeten    (rx_commadeten),
    .rx_pcommaalignen (rx_pcommaalignen),
    .rx_mcommaalignen (rx_mcommaalignen),
    .rx_polarity      (rx_polarity),
    .link_up          (link_up),
    .state            (state),
    .flip_cnt         (flip_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: advances once per rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit errW;
    bit commaW;
    errW   = |(rx_disperr | rx_notintable);
    commaW = |rx_chariscomma;
    if (!rst_n) begin
      mState = 0; mTimer = 0; mAcq = 0; mCred = 0; mRun = 0; mFlip = 0; mPol = 1'b0;
    end else if (!enable || rx_elecidle) begin
      mState = 0; mTimer = 0; mAcq = 0; mCred = 0; mRun = 0;
    end else begin
      case (mState)
        0: begin
          mState = 1; mTimer = 0;
        end
        1: begin
          if (rx_byteisaligned) begin
            mState = 2; mAcq = 0; mTimer = 0;
          end else if (mTimer == TIMEOUT - 1) begin
            mTimer = 0;
            mPol = !mPol;
            if (mFlip < 255) mFlip = mFlip + 1;
          end else begin
            mTimer = mTimer + 1;
          end
        end
        2: begin
          if (errW || rx_byterealign || !rx_byteisaligned) begin
            mState = 1; mTimer = 0; mAcq = 0;
          end else if (commaW) begin
            mAcq = mAcq + 1;
            if (mAcq == ACQ) begin
              mState = 3; mAcq = 0; mCred = 0; mRun = 0;
            end
          end
        end
        default: begin
          if (rx_byterealign) begin
            mState = 1; mTimer = 0; mCred = 0; mRun = 0;
          end else if (errW) begin
            mCred = mCred + 1; mRun = 0;
            if (mCred == THRESH) begin
              mState = 1; mTimer = 0; mCred = 0;
            end
          end else begin
            mRun = mRun + 1;
            if (mRun == GOOD) begin
              mRun = 0;
              if (mCred > 0) mCred = mCred - 1;
            end
          end
        end
      endcase
    end
  end

  function automatic logic [14:0] dutVec();
    return {state, link_up, rx_commadeten, rx_pcommaalignen, rx_mcommaalignen,
            rx_polarity, flip_cnt};
  endfunction

  function automatic logic [14:0] modelVec();
    return {2'(mState), (mState == 3), (mState != 0), (mState == 1), (mState == 1),
            mPol, 8'(mFlip)};
  endfunction

  task automatic driveWord(input logic [1:0] comma, input logic [1:0] disp,
                           input logic [1:0] nit);
    rx_chariscomma = comma;
    rx_disperr     = disp;
    rx_notintable  = nit;
  endtask

  task automatic errWord();
    if ($urandom_range(0, 1) == 0) driveWord(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)), 2'b00);
    else driveWord(2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(1, 3)));
  endtask

  // Walks the controller IDLE -> ALIGN -> ACQUIRE -> SYNC in seven edges.
  task automatic goSync();
    rx_byterealign = 1'b0;
    rx_elecidle    = 1'b0;
    enable         = 1'b0;
    driveWord(2'b00, 2'b00, 2'b00);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    rx_byteisaligned = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ACQ; i++) begin
      driveWord(2'b10, 2'b00, 2'b00);
      @(negedge clk);
    end
    driveWord(2'b00, 2'b00, 2'b00);
  endtask

  // Reset holds everything at zero, then bring-up through ALIGN to ACQUIRE.
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; rx_elecidle = 1'b0;
    rx_byteisaligned = 1'b0; rx_byterealign = 1'b0;
    driveWord(2'b00, 2'b00, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dutVec() !== 15'd0) begin
      failures++; $display("[TB] FAIL reset_outputs: got %h expected %h", dutVec(), 15'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, rx_commadeten, rx_pcommaalignen, rx_mcommaalignen} !== 5'b01_111) begin
      failures++;
      $display("[TB] FAIL bringup_align: got %b expected %b",
               {state, rx_commadeten, rx_pcommaalignen, rx_mcommaalignen}, 5'b01_111);
    end
    rx_byteisaligned = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, rx_commadeten, rx_pcommaalignen, rx_mcommaalignen} !== 5'b10_100) begin
      failures++;
      $display("[TB] FAIL bringup_acquire: got %b expected %b",
               {state, rx_commadeten, rx_pcommaalignen, rx_mcommaalignen}, 5'b10_100);
    end
  endtask

  // Four clean comma words reach SYNC; an error on the third word aborts.
  task automatic test_acquire();
    for (int i = 0; i < ACQ; i++) begin
      driveWord(2'b01, 2'b00, 2'b00);
      @(negedge clk);
      checks++;
      if ({state, link_up} !== ((i == ACQ - 1) ? 3'b11_1 : 3'b10_0)) begin
        failures++;
        $display("[TB] FAIL acquire_word%0d: got %b expected %b", i, {state, link_up},
                 ((i == ACQ - 1) ? 3'b11_1 : 3'b10_0));
      end
    end
    driveWord(2'b00, 2'b00, 2'b00);
    rx_byterealign = 1'b1;
    @(negedge clk);
    rx_byterealign = 1'b0;
    checks++;
    if (state !== 2'd1) begin
      failures++; $display("[TB] FAIL realign_in_sync: got %0d expected 1", state);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      driveWord(2'b01, (i == 2) ? 2'b10 : 2'b00, 2'b00);
      @(negedge clk);
      checks++;
      if ({state, link_up} !== ((i == 2) ? 3'b01_0 : 3'b10_0)) begin
        failures++;
        $display("[TB] FAIL acquire_err_word%0d: got %b expected %b", i, {state, link_up},
                 ((i == 2) ? 3'b01_0 : 3'b10_0));
      end
    end
    driveWord(2'b00, 2'b00, 2'b00);
  endtask

  // Alignment never found: polarity flips every 16 ALIGN cycles until aligned.
  task automatic test_polarity();
    enable = 1'b0;
    @(negedge clk);
    rx_byteisaligned = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 52; i++) begin
      if (i == 52) rx_byteisaligned = 1'b1;
      @(negedge clk);
      if (i == 15 || i == 16 || i == 31 || i == 32 || i == 48 || i == 52) begin
        checks++;
        if ({rx_polarity, flip_cnt} !== {1'((i / 16) % 2), 8'(i / 16)}) begin
          failures++;
          $display("[TB] FAIL polarity_cycle%0d: got pol=%b flips=%0d expected pol=%b flips=%0d",
                   i, rx_polarity, flip_cnt, 1'((i / 16) % 2), i / 16);
        end
      end
    end
    checks++;
    if (state !== 2'd2) begin
      failures++; $display("[TB] FAIL polarity_aligned_state: got %0d expected 2", state);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({state, rx_polarity, flip_cnt} !== {2'd2, 1'b1, 8'd3}) begin
      failures++;
      $display("[TB] FAIL polarity_hold: got state=%0d pol=%b flips=%0d expected 2/1/3",
               state, rx_polarity, flip_cnt);
    end
  endtask

  // Alignment on the timeout cycle wins: ACQUIRE and no flip.
  task automatic test_align_on_timeout();
    enable = 1'b0;
    @(negedge clk);
    rx_byteisaligned = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= TIMEOUT; i++) begin
      if (i == TIMEOUT) rx_byteisaligned = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({state, rx_polarity, flip_cnt} !== {2'd2, 1'b1, 8'd3}) begin
      failures++;
      $display("[TB] FAIL align_on_timeout: got state=%0d pol=%b flips=%0d expected 2/1/3",
               state, rx_polarity, flip_cnt);
    end
  endtask

  // Leaky bucket: a clean run of 16 removes one credit, 15 does not.
  task automatic test_leaky_bucket();
    goSync();
    checks++;
    if (state !== 2'd3) begin
      failures++; $display("[TB] FAIL bucket_sync_entry: got %0d expected 3", state);
    end
    for (int i = 0; i < 3; i++) begin errWord(); @(negedge clk); end
    for (int i = 0; i < GOOD; i++) begin driveWord(2'($urandom_range(0, 3)), 2'b00, 2'b00); @(negedge clk); end
    errWord(); @(negedge clk);
    checks++;
    if ({state, link_up} !== 3'b11_1) begin
      failures++; $display("[TB] FAIL bucket_after_run_err1: got %b expected 111", {state, link_up});
    end
    errWord(); @(negedge clk);
    checks++;
    if ({state, link_up} !== 3'b01_0) begin
      failures++; $display("[TB] FAIL bucket_after_run_err2: got %b expected 010", {state, link_up});
    end
    goSync();
    for (int i = 0; i < 3; i++) begin errWord(); @(negedge clk); end
    for (int i = 0; i < GOOD - 1; i++) begin driveWord(2'b01, 2'b00, 2'b00); @(negedge clk); end
    errWord(); @(negedge clk);
    checks++;
    if ({state, link_up} !== 3'b01_0) begin
      failures++; $display("[TB] FAIL bucket_short_run: got %b expected 010", {state, link_up});
    end
    goSync();
    for (int i = 1; i <= THRESH; i++) begin
      errWord(); @(negedge clk);
      checks++;
      if ({state, link_up} !== ((i == THRESH) ? 3'b01_0 : 3'b11_1)) begin
        failures++;
        $display("[TB] FAIL bucket_err%0d: got %b expected %b", i, {state, link_up},
                 ((i == THRESH) ? 3'b01_0 : 3'b11_1));
      end
    end
    driveWord(2'b00, 2'b00, 2'b00);
  endtask

  // Electrical idle in ACQUIRE forces IDLE and keeps polarity.
  task automatic test_idle_override();
    goSync();
    rx_byterealign = 1'b1;
    @(negedge clk);
    rx_byterealign = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd2) begin
      failures++; $display("[TB] FAIL realign_reacquire: got %0d expected 2", state);
    end
    rx_elecidle = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, rx_commadeten, rx_polarity} !== 4'b00_0_1) begin
      failures++; $display("[TB] FAIL elecidle_acquire: got %b expected 0001",
                           {state, rx_commadeten, rx_polarity});
    end
    rx_elecidle = 1'b0;
  endtask

  // Error and elecidle together in SYNC: IDLE wins and credits are cleared.
  task automatic test_err_and_idle();
    goSync();
    for (int i = 0; i < 3; i++) begin errWord(); @(negedge clk); end
    errWord();
    rx_elecidle = 1'b1;
    @(negedge clk);
    rx_elecidle = 1'b0;
    driveWord(2'b00, 2'b00, 2'b00);
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("[TB] FAIL err_and_idle: got %0d expected 0", state);
    end
    goSync();
    for (int i = 0; i < 3; i++) begin errWord(); @(negedge clk); end
    checks++;
    if (state !== 2'd3) begin
      failures++; $display("[TB] FAIL credits_cleared: got %0d expected 3", state);
    end
    errWord(); @(negedge clk);
    checks++;
    if (state !== 2'd1) begin
      failures++; $display("[TB] FAIL credits_refill_drop: got %0d expected 1", state);
    end
    driveWord(2'b00, 2'b00, 2'b00);
  endtask

  // Randomized traffic compared every cycle against the model.
  task automatic test_random();
    bit alignPhase;
    alignPhase = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) alignPhase = !alignPhase;
      rst_n            = ($urandom_range(0, 499) != 0);
      enable           = ($urandom_range(0, 99) != 0);
      rx_elecidle      = ($urandom_range(0, 99) == 0);
      rx_byteisaligned = alignPhase && ($urandom_range(0, 49) != 0);
      rx_byterealign   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) errWord();
      else driveWord(2'($urandom_range(0, 3)), 2'b00, 2'b00);
      @(negedge clk);
      checks++;
      if (dutVec() !== modelVec()) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", c, dutVec(), modelVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_polarity();
    test_align_on_timeout();
    test_leaky_bucket();
    test_idle_override();
    test_err_and_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
